// File: rtl/dino_obstacle_collide.sv
// Scrolls one cactus obstacle right-to-left, detects dino overlap, runs the
// IDLE/RUN/OVER game state machine and keeps a saturating 4-digit BCD score.
module dino_obstacle_collide #(
  parameter int unsigned TICK_DIV  = 400000,
  parameter logic [7:0]  X_START   = 8'd240,
  parameter logic [7:0]  SPEED     = 8'd2,
  parameter logic [7:0]  DINO_X_LO = 8'd20,
  parameter logic [7:0]  DINO_X_HI = 8'd35,
  parameter logic [7:0]  OBST_W    = 8'd10,
  parameter logic [7:0]  OBST_H    = 8'd20,
  parameter logic [7:0]  FLOOR_Y   = 8'd101
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        start,
  input  logic [7:0]  dinoY,
  input  logic        dinoJumpGood,
  output logic [7:0]  obstX,
  output logic        running,
  output logic        gameOver,
  output logic        collide,
  output logic [15:0] score
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StOver = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0]      obst_q, obst_d;
  logic [15:0]     score_q, score_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            collide_q, collide_d;
  logic            start_q;

  logic       start_rise, go, tick, hit;
  logic [8:0] obst_right;

  // BCD increment that sticks at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_rise = start & ~start_q;
  assign go         = start_rise | dinoJumpGood;
  assign tick       = (state_q == StRun) && (cnt_q == CntLast);

  // 9-bit compares so obstX + OBST_W cannot wrap near the right edge.
  assign obst_right = {1'b0, obst_q} + {1'b0, OBST_W};
  assign hit = ({1'b0, obst_q} <= {1'b0, DINO_X_HI}) &&
               (obst_right > {1'b0, DINO_X_LO}) &&
               ({1'b0, dinoY} < ({1'b0, FLOOR_Y} + {1'b0, OBST_H}));

  always_comb begin
    state_d   = state_q;
    obst_d    = obst_q;
    score_d   = score_q;
    cnt_d     = '0;
    collide_d = 1'b0;
    case (state_q)
      StIdle: begin
        obst_d  = X_START;
        score_d = 16'h0000;
        if (go) state_d = StRun;
      end
      StRun: begin
        if (hit) begin
          state_d   = StOver;
          collide_d = 1'b1;
        end else if (tick) begin
          if (obst_q >= SPEED) begin
            obst_d = obst_q - SPEED;
          end else begin
            obst_d  = X_START;
            score_d = bcd_inc(score_q);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StOver: begin
        if (start_rise) begin
          state_d = StRun;
          obst_d  = X_START;
          score_d = 16'h0000;
        end
      end
      default: begin
        state_d = StIdle;
        obst_d  = X_START;
        score_d = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StIdle;
      obst_q    <= X_START;
      score_q   <= 16'h0000;
      cnt_q     <= '0;
      collide_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      obst_q    <= obst_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      collide_q <= collide_d;
      start_q   <= start;
    end
  end

  assign obstX    = obst_q;
  assign running  = (state_q == StRun);
  assign gameOver = (state_q == StOver);
  assign collide  = collide_q;
  assign score    = score_q;

endmodule

// File: tb/tb_dino_obstacle_collide.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a monitor
// compares them at the falling edge of the tagged cycle.
module tb_dino_obstacle_collide;

  localparam int unsigned FObst  = 0;
  localparam int unsigned FRun   = 1;
  localparam int unsigned FOver  = 2;
  localparam int unsigned FCol   = 3;
  localparam int unsigned FScore = 4;

  typedef struct {
    int unsigned tag;
    int unsigned dut;
    int unsigned fld;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        nRst;
  logic        start1, jump1, start2, jump2;
  logic [7:0]  dinoY1, dinoY2;
  logic [7:0]  obst1, obst2;
  logic        run1, over1, col1, run2, over2, col2;
  logic [15:0] score1, score2;

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;
  exp_t        q[$];

  // Full-size game with a fast tick.
  dino_obstacle_collide #(.TICK_DIV(4)) u_dut1 (
    .clk(clk), .nRst(nRst), .start(start1), .dinoY(dinoY1), .dinoJumpGood(jump1),
    .obstX(obst1), .running(run1), .gameOver(over1), .collide(col1), .score(score1)
  );

  // Tiny track ticking every cycle: a point every 2 cycles, hit coincides with tick.
  dino_obstacle_collide #(
    .TICK_DIV(1), .X_START(8'd2), .SPEED(8'd2), .DINO_X_LO(8'd0), .DINO_X_HI(8'd35)
  ) u_dut2 (
    .clk(clk), .nRst(nRst), .start(start2), .dinoY(dinoY2), .dinoJumpGood(jump2),
    .obstX(obst2), .running(run2), .gameOver(over2), .collide(col2), .score(score2)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic string fld_name(input int unsigned f);
    case (f)
      FObst:   return "obstX";
      FRun:    return "running";
      FOver:   return "gameOver";
      FCol:    return "collide";
      default: return "score";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int unsigned d, input int unsigned f);
    case (f)
      FObst:   return (d == 0) ? {8'h00, obst1} : {8'h00, obst2};
      FRun:    return (d == 0) ? {15'd0, run1} : {15'd0, run2};
      FOver:   return (d == 0) ? {15'd0, over1} : {15'd0, over2};
      FCol:    return (d == 0) ? {15'd0, col1} : {15'd0, col2};
      default: return (d == 0) ? score1 : score2;
    endcase
  endfunction

  task automatic expect_at(input int unsigned tag, input int unsigned d,
                           input int unsigned f, input logic [15:0] v);
    exp_t e;
    int   i;
    e.tag = tag; e.dut = d; e.fld = f; e.val = v;
    i = q.size();
    while (i > 0 && q[i-1].tag > tag) i--;
    q.insert(i, e);
  endtask

  task automatic expect_all(input int unsigned tag, input int unsigned d, input logic [7:0] ox,
                            input logic r, input logic o, input logic c, input logic [15:0] s);
    expect_at(tag, d, FObst, {8'h00, ox});
    expect_at(tag, d, FRun, {15'd0, r});
    expect_at(tag, d, FOver, {15'd0, o});
    expect_at(tag, d, FCol, {15'd0, c});
    expect_at(tag, d, FScore, s);
  endtask

  task automatic go_to(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e   = q.pop_front();
        act = actual(e.dut, e.fld);
        n_vec++;
        if (e.tag != cyc || act !== e.val) begin
          n_fail++;
          $display("FAIL dut%0d %s @cyc %0d: got %h, want %h", e.dut + 1, fld_name(e.fld),
                   e.tag, act, e.val);
        end
      end
    end
  end

  initial begin : stim
    int unsigned b, s, t0, t;
    nRst = 1'b0;
    start1 = 1'b0; jump1 = 1'b0; dinoY1 = 8'd150;
    start2 = 1'b0; jump2 = 1'b0; dinoY2 = 8'd150;
    repeat (3) @(posedge clk);
    #2;
    nRst = 1'b1;
    b = cyc;
    expect_all(b + 10, 0, 8'd240, 1'b0, 1'b0, 1'b0, 16'h0000);
    expect_all(b + 10, 1, 8'd2, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Start, scroll, respawn, then a floor-level collision at obstX=34.
    go_to(b + 12);
    b = cyc;
    start1 = 1'b1;
    expect_at(b, 0, FRun, 16'd0);
    expect_all(b + 1, 0, 8'd240, 1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(b + 4, 0, FObst, 16'd240);
    expect_at(b + 5, 0, FObst, 16'd238);
    expect_at(b + 8, 0, FObst, 16'd238);
    expect_at(b + 9, 0, FObst, 16'd236);
    expect_at(b + 480, 0, FObst, 16'd2);
    expect_at(b + 481, 0, FObst, 16'd0);
    expect_at(b + 484, 0, FScore, 16'h0000);
    expect_all(b + 485, 0, 8'd240, 1'b1, 1'b0, 1'b0, 16'h0001);
    expect_all(b + 877, 0, 8'd44, 1'b1, 1'b0, 1'b0, 16'h0001);
    expect_all(b + 897, 0, 8'd34, 1'b1, 1'b0, 1'b0, 16'h0001);
    expect_all(b + 898, 0, 8'd34, 1'b0, 1'b1, 1'b1, 16'h0001);
    expect_all(b + 899, 0, 8'd34, 1'b0, 1'b1, 1'b0, 16'h0001);
    expect_all(b + 905, 0, 8'd34, 1'b0, 1'b1, 1'b0, 16'h0001);
    go_to(b + 1);
    start1 = 1'b0;
    go_to(b + 486);
    dinoY1 = 8'd101;
    go_to(b + 905);
    dinoY1 = 8'd150;

    // Restart from OVER, reach score 12 with a BCD carry, collide again.
    s = b + 910;
    go_to(s);
    start1 = 1'b1;
    expect_all(s + 1, 0, 8'd240, 1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(s + 4, 0, FObst, 16'd240);
    expect_at(s + 5, 0, FObst, 16'd238);
    expect_at(s + 4357, 0, FScore, 16'h0009);
    expect_at(s + 4840, 0, FScore, 16'h0009);
    expect_at(s + 4841, 0, FScore, 16'h0010);
    expect_at(s + 5809, 0, FScore, 16'h0012);
    expect_at(s + 6221, 0, FObst, 16'd34);
    expect_all(s + 6222, 0, 8'd34, 1'b0, 1'b1, 1'b1, 16'h0012);
    expect_at(s + 6223, 0, FCol, 16'd0);
    expect_all(s + 6226, 0, 8'd34, 1'b0, 1'b1, 1'b0, 16'h0012);
    expect_all(s + 6227, 0, 8'd34, 1'b0, 1'b1, 1'b0, 16'h0012);
    expect_all(s + 6231, 0, 8'd240, 1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(s + 6234, 0, FObst, 16'd240);
    expect_at(s + 6235, 0, FObst, 16'd238);
    expect_at(s + 6239, 0, FObst, 16'd236);
    expect_all(s + 6240, 0, 8'd240, 1'b0, 1'b0, 1'b0, 16'h0000);
    expect_at(s + 6245, 0, FRun, 16'd0);
    expect_all(s + 6246, 0, 8'd240, 1'b1, 1'b0, 1'b0, 16'h0000);
    go_to(s + 1);
    start1 = 1'b0;
    go_to(s + 5812);
    dinoY1 = 8'd101;
    go_to(s + 6225);
    jump1 = 1'b1;
    go_to(s + 6226);
    jump1 = 1'b0;
    go_to(s + 6228);
    dinoY1 = 8'd150;
    go_to(s + 6230);
    start1 = 1'b1;
    go_to(s + 6231);
    start1 = 1'b0;
    go_to(s + 6240);
    nRst = 1'b0;
    go_to(s + 6242);
    nRst = 1'b1;
    go_to(s + 6245);
    jump1 = 1'b1;
    go_to(s + 6246);
    jump1 = 1'b0;

    // Hit and tick in the same cycle: tick must be ignored.
    go_to(s + 6250);
    t0 = cyc;
    start2 = 1'b1;
    expect_all(t0 + 1, 1, 8'd2, 1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(t0 + 2, 1, FObst, 16'd0);
    expect_at(t0 + 3, 1, FScore, 16'h0001);
    expect_all(t0 + 6, 1, 8'd0, 1'b1, 1'b0, 1'b0, 16'h0002);
    expect_all(t0 + 7, 1, 8'd0, 1'b0, 1'b1, 1'b1, 16'h0002);
    expect_all(t0 + 8, 1, 8'd0, 1'b0, 1'b1, 1'b0, 16'h0002);
    go_to(t0 + 1);
    start2 = 1'b0;
    go_to(t0 + 6);
    dinoY2 = 8'd101;
    go_to(t0 + 9);
    dinoY2 = 8'd150;

    // BCD carries and saturation at 9999.
    t = t0 + 10;
    go_to(t);
    start2 = 1'b1;
    expect_all(t + 1, 1, 8'd2, 1'b1, 1'b0, 1'b0, 16'h0000);
    expect_at(t + 199, 1, FScore, 16'h0099);
    expect_at(t + 200, 1, FScore, 16'h0099);
    expect_at(t + 201, 1, FScore, 16'h0100);
    expect_at(t + 1999, 1, FScore, 16'h0999);
    expect_at(t + 2001, 1, FScore, 16'h1000);
    expect_at(t + 19997, 1, FScore, 16'h9998);
    expect_at(t + 19999, 1, FScore, 16'h9999);
    expect_all(t + 20001, 1, 8'd2, 1'b1, 1'b0, 1'b0, 16'h9999);
    expect_at(t + 20002, 1, FObst, 16'd0);
    expect_at(t + 20003, 1, FScore, 16'h9999);
    go_to(t + 1);
    start2 = 1'b0;
    go_to(t + 20006);

    if (q.size() != 0) begin
      n_vec += q.size();
      n_fail += q.size();
      $display("FAIL pending: got %0d unchecked expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
